// File: rtl/conv2_pkg.sv
// Shared definitions for the conv2 weight-memory scheduler: layer defaults,
// scheduler state encoding and the per-filter weight base address helper.
package conv2_pkg;

   localparam int unsigned CONV2_HALF_LEN    = 75;
   localparam int unsigned CONV2_NUM_FILTERS = 16;
   localparam int unsigned CONV2_ROM_LAT     = 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_DRAIN,
      ST_FDONE,
      ST_DONE
   } conv2_sched_state_t;

   // Each filter owns 2*half_len consecutive words: one half per ROM port.
   function automatic int unsigned conv2_w_base(input int unsigned filter,
                                                input int unsigned half_len = CONV2_HALF_LEN);
      return filter * 2 * half_len;
   endfunction

endpackage

// File: rtl/conv2_valid_pipe.sv
// ROM_LAT-deep shift register aligning {valid, first, last} with ROM read data.
module conv2_valid_pipe #(
   parameter int unsigned ROM_LAT = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic in_valid,
   input  logic in_first,
   input  logic in_last,
   output logic out_valid,
   output logic out_first,
   output logic out_last
);

   logic [ROM_LAT-1:0][2:0] vld_p;

   // Shift the issue flags one stage per cycle; reset flushes in-flight beats.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_p <= '0;
      end else begin
         vld_p[0] <= {in_valid, in_first, in_last};
         for (int i = 1; i < ROM_LAT; i++) begin
            vld_p[i] <= vld_p[i-1];
         end
      end
   end

   assign {out_valid, out_first, out_last} = vld_p[ROM_LAT-1];

endmodule

// File: rtl/conv2_weight_sched.sv
// Conv2 weight ROM scheduler: walks every filter, issuing dual-port address
// pairs under datapath backpressure, and re-times ROM latency into strobes.
module conv2_weight_sched
   import conv2_pkg::*;
#(
   parameter int unsigned ADDR_W      = 12,
   parameter int unsigned HALF_LEN    = CONV2_HALF_LEN,
   parameter int unsigned NUM_FILTERS = CONV2_NUM_FILTERS,
   parameter int unsigned ROM_LAT     = CONV2_ROM_LAT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              mac_ready,
   output logic              rd_en,
   output logic [ADDR_W-1:0] addr0,
   output logic [ADDR_W-1:0] addr1,
   output logic              w_valid,
   output logic              w_first,
   output logic              w_last,
   output logic [4:0]        filter_idx,
   output logic              filter_done,
   output logic              busy,
   output logic              done
);

   localparam int unsigned    K_W    = $clog2(HALF_LEN + 1);
   localparam logic [K_W-1:0] K_LAST = K_W'(HALF_LEN - 1);
   localparam logic [4:0]     F_LAST = 5'(NUM_FILTERS - 1);
   localparam logic [2:0]     D_LAST = 3'(ROM_LAT - 1);

   if (NUM_FILTERS * 2 * HALF_LEN - 1 >= (1 << ADDR_W)) begin : g_addr_chk
      $error("conv2_weight_sched: weight address range exceeds ADDR_W");
   end
   if (ROM_LAT < 1 || ROM_LAT > 4) begin : g_lat_chk
      $error("conv2_weight_sched: ROM_LAT must be 1..4");
   end
   if (NUM_FILTERS < 1 || NUM_FILTERS > 32) begin : g_filt_chk
      $error("conv2_weight_sched: NUM_FILTERS must fit filter_idx");
   end

   conv2_sched_state_t state;
   logic [K_W-1:0]     k;
   logic [2:0]         drain_cnt;
   logic               iss_first;
   logic               iss_last;

   // Scheduler FSM with all outputs registered.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         k           <= '0;
         drain_cnt   <= '0;
         iss_first   <= 1'b0;
         iss_last    <= 1'b0;
         rd_en       <= 1'b0;
         addr0       <= '0;
         addr1       <= ADDR_W'(HALF_LEN);
         filter_idx  <= '0;
         filter_done <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         filter_done <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               rd_en     <= 1'b0;
               iss_first <= 1'b0;
               iss_last  <= 1'b0;
               if (start) begin
                  state      <= ST_READ;
                  filter_idx <= '0;
                  k          <= '0;
                  done       <= 1'b0;
                  busy       <= 1'b1;
               end else if (state == ST_DONE) begin
                  done <= 1'b1;
               end
            end
            ST_READ: begin
               if (mac_ready) begin
                  rd_en     <= 1'b1;
                  addr0     <= ADDR_W'(conv2_w_base(32'(filter_idx), HALF_LEN) + 32'(k));
                  addr1     <= ADDR_W'(conv2_w_base(32'(filter_idx), HALF_LEN) + 32'(k) + HALF_LEN);
                  iss_first <= (k == '0);
                  iss_last  <= (k == K_LAST);
                  k         <= k + K_W'(1);
                  if (k == K_LAST) begin
                     state     <= ST_DRAIN;
                     drain_cnt <= '0;
                  end
               end else begin
                  // Stalled issue: addresses hold, nothing new enters the pipe.
                  rd_en     <= 1'b0;
                  iss_first <= 1'b0;
                  iss_last  <= 1'b0;
               end
            end
            ST_DRAIN: begin
               rd_en     <= 1'b0;
               iss_first <= 1'b0;
               iss_last  <= 1'b0;
               if (drain_cnt == D_LAST) begin
                  state <= ST_FDONE;
               end else begin
                  drain_cnt <= drain_cnt + 3'd1;
               end
            end
            ST_FDONE: begin
               filter_done <= 1'b1;
               if (filter_idx == F_LAST) begin
                  // Index saturates on the final filter.
                  state <= ST_DONE;
                  busy  <= 1'b0;
               end else begin
                  filter_idx <= filter_idx + 5'd1;
                  k          <= '0;
                  state      <= ST_READ;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   conv2_valid_pipe #(
      .ROM_LAT(ROM_LAT)
   ) u_valid_pipe (
      .clk      (clk),
      .reset    (reset),
      .in_valid (rd_en),
      .in_first (iss_first),
      .in_last  (iss_last),
      .out_valid(w_valid),
      .out_first(w_first),
      .out_last (w_last)
   );

endmodule

// File: tb/tb_conv2_weight_sched.sv
// Bench for conv2_weight_sched: a ROM_LAT=1 and a ROM_LAT=3 instance share
// stimulus; a scoreboard tracks expected issues and delivered beats.
module tb_conv2_weight_sched;

   logic clk = 1'b0;
   logic reset;
   logic start;
   logic mac_ready;

   logic        rd_en_w [2];
   logic [11:0] a0      [2];
   logic [11:0] a1      [2];
   logic        wv      [2];
   logic        wf      [2];
   logic        wl      [2];
   logic [4:0]  fi      [2];
   logic        fd      [2];
   logic        bz      [2];
   logic        dn      [2];

   int checks = 0;
   int passed = 0;
   int cyc    = 0;

   // Expected issues as f*1000+k, and pending beats as due*4+first*2+last.
   int iss_q  [2][$];
   int beat_q [2][$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   conv2_weight_sched #(.ROM_LAT(1)) dut (
      .clk(clk), .reset(reset), .start(start), .mac_ready(mac_ready),
      .rd_en(rd_en_w[0]), .addr0(a0[0]), .addr1(a1[0]),
      .w_valid(wv[0]), .w_first(wf[0]), .w_last(wl[0]),
      .filter_idx(fi[0]), .filter_done(fd[0]), .busy(bz[0]), .done(dn[0])
   );

   conv2_weight_sched #(.ROM_LAT(3)) dut3 (
      .clk(clk), .reset(reset), .start(start), .mac_ready(mac_ready),
      .rd_en(rd_en_w[1]), .addr0(a0[1]), .addr1(a1[1]),
      .w_valid(wv[1]), .w_first(wf[1]), .w_last(wl[1]),
      .filter_idx(fi[1]), .filter_done(fd[1]), .busy(bz[1]), .done(dn[1])
   );

   // Scoreboard: every issue must match the next expected pair, every beat
   // must arrive exactly ROM_LAT cycles later with the right first/last flags.
   always @(negedge clk) begin : mon
      int e, f, k, b, lat;
      logic [1:0] fl;
      if (reset === 1'b1) begin
         for (int d = 0; d < 2; d++) begin
            lat = (d == 0) ? 1 : 3;
            if (rd_en_w[d]) begin
               checks++;
               if (iss_q[d].size() == 0) begin
                  $display("FAIL sb_issue dut%0d: unexpected rd_en addr0=%0d at cycle %0d", d, a0[d], cyc);
               end else begin
                  e = iss_q[d].pop_front();
                  f = e / 1000;
                  k = e % 1000;
                  if (a0[d] !== 12'(f*150 + k) || a1[d] !== 12'(f*150 + k + 75)) begin
                     $display("FAIL sb_addr dut%0d: got %0d/%0d want %0d/%0d", d, a0[d], a1[d], f*150+k, f*150+k+75);
                  end else begin
                     passed++;
                  end
                  beat_q[d].push_back((cyc + lat)*4 + ((k == 0) ? 2 : 0) + ((k == 74) ? 1 : 0));
               end
            end
            if (wv[d]) begin
               checks++;
               if (beat_q[d].size() == 0) begin
                  $display("FAIL sb_beat dut%0d: unexpected w_valid at cycle %0d", d, cyc);
               end else begin
                  b  = beat_q[d].pop_front();
                  fl = 2'(b & 3);
                  if (cyc !== b/4 || {wf[d], wl[d]} !== fl) begin
                     $display("FAIL sb_beat dut%0d: got cycle %0d first/last %b want cycle %0d %b", d, cyc, {wf[d], wl[d]}, b/4, fl);
                  end else begin
                     passed++;
                  end
               end
            end else if (wf[d] || wl[d]) begin
               checks++;
               $display("FAIL sb_strobe dut%0d: first/last %b without w_valid at cycle %0d", d, {wf[d], wl[d]}, cyc);
            end
         end
      end
   end

   task automatic push_pass();
      for (int f = 0; f < 16; f++) begin
         for (int k = 0; k < 75; k++) begin
            iss_q[0].push_back(f*1000 + k);
            iss_q[1].push_back(f*1000 + k);
         end
      end
   endtask

   task automatic flush_sb();
      for (int d = 0; d < 2; d++) begin
         iss_q[d].delete();
         beat_q[d].delete();
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; mac_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({rd_en_w[d], wv[d], wf[d], wl[d], fd[d], bz[d], dn[d]} !== 7'b0) begin
            $display("FAIL reset_strobes dut%0d: got %b want 0000000", d, {rd_en_w[d], wv[d], wf[d], wl[d], fd[d], bz[d], dn[d]});
         end else passed++;
         checks++;
         if (a0[d] !== 12'd0 || a1[d] !== 12'd75 || fi[d] !== 5'd0) begin
            $display("FAIL reset_regs dut%0d: got addr %0d/%0d idx %0d want 0/75/0", d, a0[d], a1[d], fi[d]);
         end else passed++;
      end
      reset = 1'b1;
      mac_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_full_pass(input int p);
      int fd_cnt[2], wv_cnt[2], done_c[2], wf_c[2];
      int first_iss, fa0, fa1, r75, a75_0, a75_1, wl0_c, fd0_c, r78, a78_0, a78_1;
      int last_a0, last_a1, fd1_first, last_fd1, bad_period;
      for (int d = 0; d < 2; d++) begin
         fd_cnt[d] = 0; wv_cnt[d] = 0; done_c[d] = -1; wf_c[d] = -1;
      end
      first_iss = -1; fa0 = -1; fa1 = -1; r75 = 0; a75_0 = -1; a75_1 = -1;
      wl0_c = -1; fd0_c = -1; r78 = 0; a78_0 = -1; a78_1 = -1;
      last_a0 = -1; last_a1 = -1; fd1_first = -1; last_fd1 = -1; bad_period = 0;
      mac_ready = 1'b1;
      push_pass();
      pulse_start();
      checks++;
      if (dn[0] !== 1'b0 || bz[0] !== 1'b1 || dn[1] !== 1'b0 || bz[1] !== 1'b1) begin
         $display("FAIL pass%0d_start: done %b%b busy %b%b want 00/11", p, dn[0], dn[1], bz[0], bz[1]);
      end else passed++;
      for (int c = 0; c <= 1300; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
         end
         for (int d = 0; d < 2; d++) begin
            if (wv[d]) wv_cnt[d]++;
            if (fd[d]) fd_cnt[d]++;
            if (dn[d] && done_c[d] < 0) done_c[d] = c;
            if (wf[d] && wf_c[d] < 0) wf_c[d] = c;
         end
         if (rd_en_w[0] && first_iss < 0) begin first_iss = c; fa0 = a0[0]; fa1 = a1[0]; end
         if (c == 75) begin r75 = rd_en_w[0]; a75_0 = a0[0]; a75_1 = a1[0]; end
         if (c == 78) begin r78 = rd_en_w[0]; a78_0 = a0[0]; a78_1 = a1[0]; end
         if (wl[0] && wl0_c < 0) wl0_c = c;
         if (fd[0] && fd0_c < 0) fd0_c = c;
         if (rd_en_w[0]) begin last_a0 = a0[0]; last_a1 = a1[0]; end
         if (fd[1]) begin
            if (last_fd1 >= 0 && c - last_fd1 != 79) bad_period++;
            if (last_fd1 < 0) fd1_first = c;
            last_fd1 = c;
         end
      end
      checks++;
      if (first_iss != 1 || fa0 != 0 || fa1 != 75) begin
         $display("FAIL pass%0d_first_issue: cycle %0d addr %0d/%0d want 1 0/75", p, first_iss, fa0, fa1);
      end else passed++;
      checks++;
      if (wf_c[0] != 2 || wf_c[1] != 4) begin
         $display("FAIL pass%0d_w_first: cycles %0d/%0d want 2/4", p, wf_c[0], wf_c[1]);
      end else passed++;
      checks++;
      if (r75 != 1 || a75_0 != 74 || a75_1 != 149) begin
         $display("FAIL pass%0d_last_issue_f0: rd_en %0d addr %0d/%0d want 1 74/149", p, r75, a75_0, a75_1);
      end else passed++;
      checks++;
      if (wl0_c != 76 || fd0_c != 77) begin
         $display("FAIL pass%0d_w_last_fdone: cycles %0d/%0d want 76/77", p, wl0_c, fd0_c);
      end else passed++;
      checks++;
      if (r78 != 1 || a78_0 != 150 || a78_1 != 225) begin
         $display("FAIL pass%0d_filter1_issue: rd_en %0d addr %0d/%0d want 1 150/225", p, r78, a78_0, a78_1);
      end else passed++;
      checks++;
      if (fd_cnt[0] != 16 || fd_cnt[1] != 16 || wv_cnt[0] != 1200 || wv_cnt[1] != 1200) begin
         $display("FAIL pass%0d_counts: filter_done %0d/%0d w_valid %0d/%0d want 16/16 1200/1200", p, fd_cnt[0], fd_cnt[1], wv_cnt[0], wv_cnt[1]);
      end else passed++;
      checks++;
      if (done_c[0] != 1233 || done_c[1] != 1265) begin
         $display("FAIL pass%0d_done_cycle: %0d/%0d want 1233/1265", p, done_c[0], done_c[1]);
      end else passed++;
      checks++;
      if (last_a0 != 2324 || last_a1 != 2399) begin
         $display("FAIL pass%0d_last_pair: %0d/%0d want 2324/2399", p, last_a0, last_a1);
      end else passed++;
      checks++;
      if (fd1_first != 79 || bad_period != 0) begin
         $display("FAIL pass%0d_lat3_period: first fdone %0d bad periods %0d want 79/0", p, fd1_first, bad_period);
      end else passed++;
      checks++;
      if (dn[0] !== 1'b1 || dn[1] !== 1'b1 || bz[0] !== 1'b0 || bz[1] !== 1'b0 || fi[0] !== 5'd15 || fi[1] !== 5'd15) begin
         $display("FAIL pass%0d_done_state: done %b%b busy %b%b idx %0d/%0d want 11/00 15/15", p, dn[0], dn[1], bz[0], bz[1], fi[0], fi[1]);
      end else passed++;
      checks++;
      if (iss_q[0].size() != 0 || iss_q[1].size() != 0 || beat_q[0].size() != 0 || beat_q[1].size() != 0) begin
         $display("FAIL pass%0d_sb_empty: pending issues %0d/%0d beats %0d/%0d want 0", p, iss_q[0].size(), iss_q[1].size(), beat_q[0].size(), beat_q[1].size());
      end else passed++;
   endtask

   task automatic test_backpressure();
      logic hit;
      int hold_bad, beats[2];
      hit = 1'b0; hold_bad = 0; beats[0] = 0; beats[1] = 0;
      mac_ready = 1'b1;
      push_pass();
      pulse_start();
      for (int c = 0; c < 100 && !hit; c++) begin
         @(posedge clk); #1;
         if (rd_en_w[0] && a0[0] == 12'd40) hit = 1'b1;
      end
      checks++;
      if (!hit) $display("FAIL bp_reach_k40: issue of addr0=40 not seen, got %b want 1", hit);
      else passed++;
      mac_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         for (int d = 0; d < 2; d++) begin
            if (rd_en_w[d] || a0[d] != 12'd40 || a1[d] != 12'd115) hold_bad++;
            if (wv[d]) beats[d]++;
         end
      end
      checks++;
      if (hold_bad != 0) $display("FAIL bp_hold: %0d bad cycles want 0", hold_bad);
      else passed++;
      checks++;
      if (beats[0] != 1 || beats[1] != 3) $display("FAIL bp_inflight: beats %0d/%0d want 1/3", beats[0], beats[1]);
      else passed++;
      mac_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (!rd_en_w[0] || !rd_en_w[1] || a0[0] != 12'd41 || a1[0] != 12'd116 || a0[1] != 12'd41 || a1[1] != 12'd116) begin
         $display("FAIL bp_resume: rd_en %b%b addr %0d/%0d %0d/%0d want 11 41/116", rd_en_w[0], rd_en_w[1], a0[0], a1[0], a0[1], a1[1]);
      end else passed++;
   endtask

   task automatic test_start_ignored();
      logic [4:0] idx0;
      repeat (5) @(posedge clk);
      #1;
      idx0 = fi[0];
      pulse_start();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bz[0] !== 1'b1 || bz[1] !== 1'b1 || dn[0] !== 1'b0 || fi[0] !== idx0 || a0[0] < 12'd41) begin
         $display("FAIL start_ignored: busy %b%b done %b idx %0d addr0 %0d want 11 0 %0d >=41", bz[0], bz[1], dn[0], fi[0], a0[0], idx0);
      end else passed++;
   endtask

   task automatic test_reset_midpass();
      logic hit;
      int stray;
      hit = 1'b0; stray = 0;
      for (int c = 0; c < 700 && !hit; c++) begin
         @(posedge clk); #1;
         if (fi[0] == 5'd5 && rd_en_w[0] && a0[0] == 12'd760) hit = 1'b1;
      end
      checks++;
      if (!hit) $display("FAIL rst_reach_f5: filter 5 k=10 not seen, got %b want 1", hit);
      else passed++;
      #1;
      reset = 1'b0;
      #1;
      flush_sb();
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({rd_en_w[d], wv[d], wf[d], wl[d], fd[d], bz[d], dn[d]} !== 7'b0) begin
            $display("FAIL rst_async_strobes dut%0d: got %b want 0000000", d, {rd_en_w[d], wv[d], wf[d], wl[d], fd[d], bz[d], dn[d]});
         end else passed++;
         checks++;
         if (a0[d] !== 12'd0 || a1[d] !== 12'd75 || fi[d] !== 5'd0) begin
            $display("FAIL rst_async_regs dut%0d: got addr %0d/%0d idx %0d want 0/75/0", d, a0[d], a1[d], fi[d]);
         end else passed++;
      end
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         for (int d = 0; d < 2; d++) begin
            if (rd_en_w[d] || wv[d] || bz[d] || dn[d] || fd[d]) stray++;
         end
      end
      checks++;
      if (stray != 0) $display("FAIL rst_release_quiet: %0d active strobes want 0", stray);
      else passed++;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_full_pass(0);
      test_full_pass(1);
      test_backpressure();
      test_start_ignored();
      test_reset_midpass();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/conv2_weight_sched.md
# conv2_weight_sched

Scheduler for the Convolution 2 layer weight memory. On `start` it walks all conv2 filters in order. For each filter it issues dual-port reads of the filter's 150 weights as 75 address pairs, stalling on datapath backpressure, and re-times the ROM read latency into valid/first/last strobes for the MAC datapath. It sits between the layer-level controller (start/done) and the conv2 weight ROM plus MAC array, and replaces free-running address counters with a handshaked, per-filter sequence.

## Interface
Parameters:
- `ADDR_W`, 12: weight ROM address width.
- `HALF_LEN`, 75: weight pairs per filter (half of 6 channels × 25 taps).
- `NUM_FILTERS`, 16: conv2 output filters.
- `ROM_LAT`, 1: ROM read latency in cycles, 1..4.

Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `reset`, input, 1: asynchronous, active-low; 0 forces the reset state immediately.
- `start`, input, 1: begin a full pass; sampled only in IDLE or DONE.
- `mac_ready`, input, 1: datapath can take a new issue this cycle.
- `rd_en`, output, 1: ROM read strobe for both ports.
- `addr0`, output, ADDR_W: port 0 address (channels 0–2 half).
- `addr1`, output, ADDR_W: port 1 address (channels 3–5 half).
- `w_valid`, output, 1: ROM data valid this cycle; equals `rd_en` delayed by ROM_LAT.
- `w_first`, output, 1: with `w_valid`, marks the first pair of a filter (clear the accumulator).
- `w_last`, output, 1: with `w_valid`, marks the last pair of a filter.
- `filter_idx`, output, 5: index of the filter being read.
- `filter_done`, output, 1: one-cycle pulse after the last pair of each filter is delivered.
- `busy`, output, 1: high in every state except IDLE and DONE.
- `done`, output, 1: level; held high from pass completion until the next `start`.

## Operation
- All outputs are registered.
- Reset values: `rd_en`, `w_valid`, `w_first`, `w_last`, `filter_done`, `busy` and `done` are 0. `filter_idx` is 0. `addr0` is 0 and `addr1` is HALF_LEN. The internal pair counter `k` is 0. State is IDLE.
- FSM states: IDLE, READ, DRAIN, FDONE, DONE.
- IDLE or DONE with `start`=1 → READ. `filter_idx` and `k` are set to 0 and `done` is cleared.
- READ:
  - When `mac_ready`=1, assert `rd_en` with addr0 = filter_idx·2·HALF_LEN + k and addr1 = addr0 + HALF_LEN, then increment `k`.
  - When `mac_ready`=0, `rd_en` is 0 and the addresses hold.
  - After the issue with k = HALF_LEN−1, go to DRAIN.
- DRAIN: stay ROM_LAT cycles with `rd_en`=0, then go to FDONE.
- FDONE:
  - Pulse `filter_done` for one cycle and increment `filter_idx`.
  - If the new index equals NUM_FILTERS, go to DONE with `done`=1 and `filter_idx` saturated at NUM_FILTERS−1.
  - Otherwise reset `k` to 0 and go to READ.
- Address arithmetic is unsigned, with no wrap. The maximum address is NUM_FILTERS·2·HALF_LEN−1 = 2399 < 2^ADDR_W; this is a static check at elaboration.
- `w_first` and `w_last` are the k=0 and k=HALF_LEN−1 flags, delayed through the same ROM_LAT pipe as `w_valid`.
- Backpressure applies to new issues only. Up to ROM_LAT in-flight pairs are always delivered, so the datapath must absorb ROM_LAT beats after dropping `mac_ready`.
- `start` while `busy` is ignored.
- Reset mid-pass aborts immediately. The valid pipe is flushed, so no stray `w_valid` appears after reset is released.

## Timing
- `start` sampled in cycle 0 gives the first `rd_en` in cycle 1 if `mac_ready`=1.
- Data for an issue in cycle t appears with `w_valid` in cycle t+ROM_LAT.
- With `mac_ready` held high, each filter takes HALF_LEN + ROM_LAT + 1 cycles: 77 at the defaults.
- With `mac_ready` held high at the defaults, `done` rises in cycle 1 + 16·77 = 1233.
- `filter_done` fires in the cycle after the `w_last` beat.
- `w_first` of the next filter comes no earlier than 1 + ROM_LAT cycles after `filter_done`.

## Structure
- Package `conv2_pkg` holds:
  - the HALF_LEN, NUM_FILTERS and ROM_LAT defaults;
  - the state enum `conv2_sched_state_t`;
  - a function `conv2_w_base(filter)` returning filter·2·HALF_LEN.
- Sub-module `conv2_valid_pipe`: a ROM_LAT-deep shift register carrying {valid, first, last}. It is cleared by the asynchronous reset.

## Test plan
- Reset, then `start` with `mac_ready`=1 at defaults:
  - first `rd_en` in cycle 1 with addr0=0, addr1=75;
  - `w_first` in cycle 2;
  - `w_last` in cycle 76, with addr0=74, addr1=149 issued in cycle 75;
  - `filter_done` in cycle 77;
  - filter 1 issues start at addr0=150, addr1=225.
- Full pass: exactly 16 `filter_done` pulses and 1200 `w_valid` beats, `done`=1 in cycle 1233, last pair addr0=2324, addr1=2399.
- Drop `mac_ready` for 10 cycles at k=40: addresses hold at 40/115, exactly ROM_LAT further `w_valid` beats arrive, then issues resume at k=41 with no pair skipped or repeated.
- Repeat with ROM_LAT=3: `w_valid`, `w_first` and `w_last` lag `rd_en` by 3 cycles, and the per-filter period is 79 cycles.
- Pulse `start` mid-pass: it is ignored. Assert `reset`=0 mid-filter 5: all outputs return to reset values asynchronously, and there is no `w_valid` after release.
- Pulse `start` in DONE: `done` clears and a second pass repeats the first bit-for-bit.
